dmem_responder: RTL and testbench

Data-memory responder for the core's data port: the slave end of the request interface driven by the decode stage's `dmem_in` (`mem_valid`, `mem_instr`, `mem_addr`, `mem_wdata`, `mem_wstrb`). It accepts one request at a time into a word-organised scratchpad, inserts a programmable number of wait states, then returns a one-cycle `mem_ready` pulse with read data or an error flag. It sits between the pipeline and on-chip data SRAM and serves as the bench model for wait-state testing.

---
 rtl/dmem_responder.sv | 91 +++++++++
 tb/tb_dmem_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-organised data scratchpad answering one request at a time
// after a fixed number of wait states, with a one-cycle ready pulse.
module dmem_responder #(
    parameter int          DEPTH_LOG2  = 12,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_error,
    output logic        busy,
    output logic        overrun
);

    localparam logic [0:0]  IDLE      = 1'b0;
    localparam logic [0:0]  BUSY      = 1'b1;
    localparam logic [32:0] LIMIT     = 33'd4 << DEPTH_LOG2;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    logic [0:0]            state;
    logic [3:0]            cnt;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic [3:0]            req_wstrb;
    logic [31:0]           mem [2**DEPTH_LOG2];
    logic [31:0]           off;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  done;

    // Offset wraps modulo 2^32, so addresses below BASE_ADDR land out of range.
    assign off      = req_addr - BASE_ADDR;
    assign in_range = {1'b0, off} < LIMIT;
    assign idx      = off[DEPTH_LOG2+1:2];
    assign done     = (state == BUSY) && (cnt == 4'd0);
    assign busy     = (state == BUSY);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_addr  <= 32'd0;
            req_wdata <= 32'd0;
            req_wstrb <= 4'd0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
            mem_error <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            mem_ready <= 1'b0;
            mem_rdata <= 32'd0;
            mem_error <= 1'b0;
            if (state == IDLE) begin
                if (mem_valid) begin
                    req_addr  <= mem_addr;
                    req_wdata <= mem_wdata;
                    req_wstrb <= mem_instr ? 4'd0 : mem_wstrb;
                    cnt       <= WAIT_INIT;
                    state     <= BUSY;
                end
            end else begin
                if (mem_valid) overrun <= 1'b1;
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    state     <= IDLE;
                    mem_ready <= 1'b1;
                    mem_error <= !in_range;
                    if (in_range && req_wstrb == 4'd0) mem_rdata <= mem[idx];
                end
            end
        end
    end

    // Array is never reset; reset at the completion edge suppresses the write.
    always_ff @(posedge clk) begin
        if (rst && done && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (req_wstrb[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: three responders with 0, 1 and 3 wait states,
// directed requests push expected responses, a monitor checks them.
module tb_dmem_responder;

    localparam int WS [3] = '{0, 1, 3};

    typedef struct {
        int          g;
        int          at;
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  valid = '0;
    logic [2:0]  instr = '0;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  wstrb [3];
    logic [2:0]  ready;
    logic [31:0] rdata [3];
    logic [2:0]  err;
    logic [2:0]  bsy;
    logic [2:0]  ovr;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .DEPTH_LOG2 (12),
            .WAIT_CYCLES(WS[g]),
            .BASE_ADDR  (32'h0000_0000)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .mem_valid(valid[g]),
            .mem_instr(instr[g]),
            .mem_addr (addr[g]),
            .mem_wdata(wdata[g]),
            .mem_wstrb(wstrb[g]),
            .mem_ready(ready[g]),
            .mem_rdata(rdata[g]),
            .mem_error(err[g]),
            .busy     (bsy[g]),
            .overrun  (ovr[g])
        );
    end

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest expectation.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (ready[g]) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ready inst %0d cycle %0d", g, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk($sformatf("inst%0d", g), 32'(g), 32'(e.g));
                    chk($sformatf("cycle%0d", g), 32'(cyc), 32'(e.at));
                    chk($sformatf("rdata%0d", g), rdata[g], e.d);
                    chk($sformatf("error%0d", g), {31'd0, err[g]}, {31'd0, e.e});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issue in current cycle; return one cycle later with valid dropped.
    task automatic issue(input int g, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input logic in, input logic [31:0] ed,
                         input logic ee, input bit expect_resp);
        exp_t e;
        valid[g] = 1'b1;
        instr[g] = in;
        addr[g]  = a;
        wdata[g] = d;
        wstrb[g] = s;
        e.g  = g;
        e.at = cyc + 2 + WS[g];
        e.d  = ed;
        e.e  = ee;
        if (expect_resp) sb.push_back(e);
        tick(1);
        valid[g] = 1'b0;
        instr[g] = 1'b0;
    endtask

    // Issue and land in the ready cycle, where the next request may go.
    task automatic xfer(input int g, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic in, input logic [31:0] ed,
                        input logic ee);
        issue(g, a, d, s, in, ed, ee, 1'b1);
        tick(WS[g] + 1);
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            addr[g]  = '0;
            wdata[g] = '0;
            wstrb[g] = '0;
        end
        tick(3);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("reset_out%0d", g),
                {rdata[g][28:0], ready[g], err[g], bsy[g] | ovr[g]}, 32'd0);
        end
        rst = 1'b1;
        tick(1);

        // W=1: full write then read, busy visible one cycle after request
        issue(1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'd0, 1'b0, 1'b1);
        chk("busy_w1", {31'd0, bsy[1]}, 32'd1);
        tick(2);
        xfer(1, 32'h10, 32'd0, 4'h0, 1'b0, 32'hDEADBEEF, 1'b0);
        xfer(1, 32'h20, 32'h11223344, 4'hF, 1'b0, 32'd0, 1'b0);
        xfer(1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, 32'd0, 1'b0);
        xfer(1, 32'h20, 32'd0, 4'h0, 1'b0, 32'h11BB33DD, 1'b0);
        xfer(1, 32'h20, 32'h0, 4'hF, 1'b1, 32'h11BB33DD, 1'b0);
        xfer(1, 32'h20, 32'd0, 4'h0, 1'b0, 32'h11BB33DD, 1'b0);
        xfer(1, 32'h4000, 32'd0, 4'h0, 1'b0, 32'd0, 1'b1);
        xfer(1, 32'h4000, 32'h12345678, 4'hF, 1'b0, 32'd0, 1'b1);
        xfer(1, 32'h3FFC, 32'h0BADCAFE, 4'hF, 1'b0, 32'd0, 1'b0);
        xfer(1, 32'h3FFC, 32'd0, 4'h0, 1'b0, 32'h0BADCAFE, 1'b0);
        xfer(1, 32'hFFFF_FFFC, 32'd0, 4'h0, 1'b0, 32'd0, 1'b1);
        tick(1);
        chk("idle_zero_w1", {rdata[1][29:0], ready[1], err[1]}, 32'd0);

        // W=0: back-to-back requests every other cycle
        xfer(0, 32'h40, 32'hCAFEF00D, 4'hF, 1'b0, 32'd0, 1'b0);
        xfer(0, 32'h40, 32'd0, 4'h0, 1'b0, 32'hCAFEF00D, 1'b0);
        xfer(0, 32'h44, 32'h01020304, 4'hF, 1'b0, 32'd0, 1'b0);
        xfer(0, 32'h44, 32'd0, 4'h0, 1'b0, 32'h01020304, 1'b0);
        chk("no_overrun_w0", {31'd0, ovr[0]}, 32'd0);

        // Request during busy is dropped and only raises overrun
        issue(0, 32'h40, 32'd0, 4'h0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b1);
        issue(0, 32'h40, 32'h0, 4'hF, 1'b0, 32'd0, 1'b0, 1'b0);
        chk("overrun_w0", {31'd0, ovr[0]}, 32'd1);
        tick(1);
        xfer(0, 32'h40, 32'd0, 4'h0, 1'b0, 32'hCAFEF00D, 1'b0);
        tick(1);

        // W=3: reset during busy abandons a pending write
        xfer(2, 32'h30, 32'h12345678, 4'hF, 1'b0, 32'd0, 1'b0);
        tick(1);
        issue(2, 32'h30, 32'hFFFFFFFF, 4'hF, 1'b0, 32'd0, 1'b0, 1'b0);
        tick(1);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("post_reset%0d", g),
                {rdata[g][28:0], ready[g], err[g], bsy[g] | ovr[g]}, 32'd0);
        end
        tick(6);
        xfer(2, 32'h30, 32'd0, 4'h0, 1'b0, 32'h12345678, 1'b0);
        tick(2);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
